irq_ctl: RTL

Interrupt controller in front of the core's pipeline control FSM. It collects up to `N_SRC` external interrupt sources and latches edge or level requests. It arbitrates them by fixed priority and drives the single `irq` request the control FSM consumes. It hands the winning source ID to the exception logic on `iack`, then blocks further requests until end-of-interrupt (the `RET` path) signals `eoi`.

---
 rtl/irq_pkg.sv | 19 +
 rtl/irq_prio_enc.sv | 20 ++
 rtl/irq_ctl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared encodings for the interrupt controller: FSM states, config register
// selects and the reserved spurious ID.
package irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } irq_state_e;

  // Write side: SWSET / PCLR. Read side at the same addresses: PEND / PEND & IEN.
  localparam logic [1:0] CFG_IEN   = 2'd0;
  localparam logic [1:0] CFG_EDGE  = 2'd1;
  localparam logic [1:0] CFG_SWSET = 2'd2;
  localparam logic [1:0] CFG_PCLR  = 2'd3;

  localparam logic [3:0] IRQ_SPURIOUS = 4'hF;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the index of
// the lowest set bit (index 0 is the highest priority).
module irq_prio_enc #(
  parameter int N_SRC = 8
) (
  input  logic [N_SRC-1:0] req,
  output logic             any,
  output logic [3:0]       idx
);

  always_comb begin
    idx = 4'd0;
    // Scan downward so the lowest set index is the last one written.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = 4'(i);
    end
    any = |req;
  end

endmodule

// File: rtl/irq_ctl.sv
// Interrupt controller: latches edge/level requests, arbitrates by fixed
// priority and hands one request at a time to the pipeline control FSM.
module irq_ctl
  import irq_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int ID_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src,
  input  logic             iack,
  input  logic             eoi,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [N_SRC-1:0] cfg_wdata,
  output logic [N_SRC-1:0] cfg_rdata,
  output logic             irq,
  output logic [ID_W-1:0]  irq_id,
  output logic             in_service
);

  logic [N_SRC-1:0] ien_reg, edge_reg, pend_reg, src_d_reg;
  logic [N_SRC-1:0] pend_next;
  irq_state_e       state_reg, state_next;
  logic             irq_reg, irq_next;
  logic [ID_W-1:0]  irq_id_reg, irq_id_next;
  logic             in_service_reg, in_service_next;

  logic [N_SRC-1:0] cand, rise, swset, pclr, ack_clr, win_onehot;
  logic             any;
  logic [3:0]       win_idx;
  logic             ack_take;

  assign cand = pend_reg & ien_reg;

  irq_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
    .req (cand),
    .any (any),
    .idx (win_idx)
  );

  assign rise       = src & ~src_d_reg;
  assign swset      = (cfg_we && cfg_addr == CFG_SWSET) ? cfg_wdata : '0;
  assign pclr       = (cfg_we && cfg_addr == CFG_PCLR)  ? cfg_wdata : '0;
  assign win_onehot = N_SRC'(1) << win_idx;
  assign ack_take   = (state_reg == ST_REQ) && iack && any;
  assign ack_clr    = ack_take ? win_onehot : '0;

  // Set terms are OR-ed in after the clears so a coincident edge survives.
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_pend
      always_comb begin
        if (edge_reg[gi])
          pend_next[gi] = (pend_reg[gi] & ~(pclr[gi] | ack_clr[gi])) | rise[gi] | swset[gi];
        else
          pend_next[gi] = src[gi];
      end
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    irq_id_next     = irq_id_reg;
    in_service_next = in_service_reg;
    case (state_reg)
      ST_IDLE: begin
        if (any) state_next = ST_REQ;
      end
      ST_REQ: begin
        if (iack) begin
          in_service_next = 1'b1;
          irq_id_next     = any ? ID_W'(win_idx) : ID_W'(IRQ_SPURIOUS);
          state_next      = ST_SERV;
        end else if (!any) begin
          state_next = ST_IDLE;
        end
      end
      ST_SERV: begin
        if (eoi) begin
          in_service_next = 1'b0;
          state_next      = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // irq must already be low in the cycle after iack to prevent re-entry.
    irq_next = (state_next == ST_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ien_reg        <= '0;
      edge_reg       <= '0;
      pend_reg       <= '0;
      src_d_reg      <= '0;
      state_reg      <= ST_IDLE;
      irq_reg        <= 1'b0;
      irq_id_reg     <= '0;
      in_service_reg <= 1'b0;
    end else begin
      if (cfg_we && cfg_addr == CFG_IEN)  ien_reg  <= cfg_wdata;
      if (cfg_we && cfg_addr == CFG_EDGE) edge_reg <= cfg_wdata;
      pend_reg       <= pend_next;
      src_d_reg      <= src;
      state_reg      <= state_next;
      irq_reg        <= irq_next;
      irq_id_reg     <= irq_id_next;
      in_service_reg <= in_service_next;
    end
  end

  always_comb begin
    case (cfg_addr)
      CFG_IEN:   cfg_rdata = ien_reg;
      CFG_EDGE:  cfg_rdata = edge_reg;
      CFG_SWSET: cfg_rdata = pend_reg;
      default:   cfg_rdata = cand;
    endcase
  end

  assign irq        = irq_reg;
  assign irq_id     = irq_id_reg;
  assign in_service = in_service_reg;

endmodule
